// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle MIPS-style control FSM with memory-wait watchdog.
// Define UC_BNE_EN to add bne decoding and the branch_ne output.
module unidad_control_multiciclo #(
   parameter int MEM_WAIT_MAX = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       ext_sel,
   output logic [3:0] state,
`ifdef UC_BNE_EN
   output logic       branch_ne,
`endif
   output logic       illegal
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      I_EXEC   = 4'd10,
      I_WB     = 4'd11,
      TRAP     = 4'd12
   } state_t;
   state_t     cur, nxt;
   logic [7:0] cnt;
   logic       is_sw, is_ext;
   logic       wait_st, timeout, bne_op;
   logic       unused_in;
   // funct and zero are consumed by the datapath, not by this FSM
   assign unused_in = ^{funct, zero};
   assign wait_st   = cur == FETCH || cur == MEM_RD || cur == MEM_WR;
   // the cycle that would bring the counter to MEM_WAIT_MAX; ready in that cycle still wins
   assign timeout   = wait_st && !mem_ready && cnt == 8'(MEM_WAIT_MAX - 1);
   assign state     = reset ? 4'd0 : cur;
`ifdef UC_BNE_EN
   logic is_bne;
   assign bne_op    = opcode == 6'b000101;
   assign branch_ne = !reset && cur == BRANCH && is_bne;
`else
   assign bne_op    = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         cur    <= FETCH;
         cnt    <= '0;
         is_sw  <= 1'b0;
         is_ext <= 1'b0;
`ifdef UC_BNE_EN
         is_bne <= 1'b0;
`endif
      end else begin
         cur <= nxt;
         cnt <= (nxt != cur) ? '0 : (wait_st && !mem_ready) ? cnt + 8'd1 : cnt;
         if (cur == DECODE) begin
            is_sw  <= opcode == 6'b101011;
            is_ext <= opcode == 6'b001100 || opcode == 6'b001101 || opcode == 6'b001110;
`ifdef UC_BNE_EN
            is_bne <= bne_op;
`endif
         end
      end
   end
   always_comb begin
      nxt           = cur;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      ext_sel       = 1'b0;
      illegal       = 1'b0;
      if (!reset) begin
         case (cur)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               nxt       = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               nxt = (opcode == 6'b000000) ? R_EXEC :
                     (opcode == 6'b100011 || opcode == 6'b101011) ? MEM_ADDR :
                     (opcode == 6'b000100 || bne_op) ? BRANCH :
                     (opcode == 6'b000010) ? JUMP :
                     (opcode == 6'b001000 || opcode == 6'b001010 || opcode == 6'b001100 ||
                      opcode == 6'b001101 || opcode == 6'b001110) ? I_EXEC : TRAP;
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               nxt       = is_sw ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               nxt      = mem_ready ? MEM_WB : timeout ? TRAP : MEM_RD;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               nxt        = FETCH;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               nxt       = mem_ready ? FETCH : timeout ? TRAP : MEM_WR;
            end
            R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               nxt       = R_WB;
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               nxt       = FETCH;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_source     = 2'b01;
               pc_write_cond = 1'b1;
               nxt           = FETCH;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               nxt       = FETCH;
            end
            I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_op    = 2'b11;
               ext_sel   = is_ext;
               nxt       = I_WB;
            end
            I_WB: begin
               reg_write = 1'b1;
               ext_sel   = is_ext;
               nxt       = FETCH;
            end
            TRAP: begin
               illegal = 1'b1;
               nxt     = TRAP;
            end
            default: nxt = TRAP;
         endcase
      end
   end
endmodule
